wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of writeback requesters (0=ALU, 1=MUL, 2=DIV, 3=LSU).
REQ-002 Parameter TAG_W, default = width of instr_tag field, instruction age tag width.
REQ-003 clk  input  1  single clock; all state rises on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 src_valid  input  NUM_SRC  requester has a result pending.
REQ-006 src_rd_addr  input  NUM_SRC x 5  destination register per requester.
REQ-007 src_data  input  NUM_SRC x XLEN  result per requester.
REQ-008 src_tag  input  NUM_SRC x TAG_W  issue-order tag per requester.
REQ-009 src_ready  output  NUM_SRC  one-hot grant; result consumed this cycle when valid & ready.
REQ-010 exu_wb_rd_addr  output  5  registered writeback address to register file/forwarding.
REQ-011 exu_wb_data  output  XLEN  registered writeback data.
REQ-012 exu_wb_rd_wr_en  output  1  registered writeback strobe.
REQ-013 wb_backlog  output  NUM_SRC  registered; bit i set when src i was valid but not granted last cycle.

Function
REQ-014 Exactly zero or one src_ready bit SHALL be high per cycle; src_ready is combinational from src_valid, src_rd_addr, src_tag and state.
REQ-015 Default policy SHALL be round-robin: search starts at (last_grant+1) mod NUM_SRC, first valid source wins.
REQ-016 WAW rule: a valid source SHALL be ineligible while another valid source has the same nonzero rd_addr and an older tag.
REQ-017 Tag age: a older than b when MSB of (a - b) mod 2^TAG_W is 1; equal tags never occur and need no handling.
REQ-018 rd_addr 0 requests SHALL be ignored by the WAW rule, granted normally, and produce wr_en 0.
REQ-019 Grant at cycle N SHALL appear on exu_wb_* at cycle N+1 (one-cycle latency); wr_en high for exactly one cycle per nonzero-rd grant.
REQ-020 Cycle with no grant: exu_wb_rd_wr_en 0 next cycle; exu_wb_rd_addr and exu_wb_data hold previous values.
REQ-021 last_grant SHALL update only on a grant; unchanged in idle cycles.
REQ-022 A requester holding valid SHALL keep rd_addr/data/tag stable until granted; arbiter behaviour is undefined otherwise.
REQ-023 Starvation bound: any continuously valid, WAW-eligible source SHALL be granted within NUM_SRC cycles.
REQ-024 Single valid source with nonzero rd SHALL be granted the same cycle (no bubble).
REQ-025 wb_backlog SHALL be registered src_valid & ~src_ready.

Reset
REQ-026 On rst_n low, asynchronously: exu_wb_rd_wr_en=0, exu_wb_rd_addr=0, exu_wb_data=0, wb_backlog=0, last_grant=NUM_SRC-1 (so source 0 has first priority).
REQ-027 src_ready SHALL be 0 while rst_n is low; a request pending at reset assertion is dropped, the requester re-presents it.

Structure
REQ-028 Source index enum (WB_SRC_ALU/MUL/DIV/LSU) and NUM_SRC constant SHALL live in types.svh; XLEN from global.svh.
REQ-029 Output register SHALL use dff_rst (async active-low) for a single packed {wr_en, rd_addr, data} word.
REQ-030 Sub-module rr_pick (masked round-robin one-hot picker, parameter N) is natural; WAW masking stays in wb_arbiter.

Verification
REQ-031 Reset: assert rst_n low mid-transaction with src_valid=4'b1111 -> src_ready=0, all outputs 0, first grant after release to src 0.
REQ-032 Single: src2 valid rd=5 data=0xDEAD_BEEF -> src_ready=4'b0100 same cycle; next cycle wr_en=1, rd=5, data=0xDEAD_BEEF.
REQ-033 Round-robin: all four valid, distinct rd 1..4, held -> grants 0,1,2,3 on consecutive cycles, wr_en 4 consecutive cycles.
REQ-034 WAW: src1 rd=7 tag=3, src3 rd=7 tag=1 (last_grant=0) -> src3 granted first, src1 next; final rd7 data = src1 data.
REQ-035 Tag wrap (TAG_W=4): src0 tag=15, src1 tag=0, both rd=9 -> src0 granted first.
REQ-036 x0: src0 rd=0 valid alone -> src_ready=4'b0001, next cycle wr_en=0; backlog check: src1,src2 valid same cycle -> wb_backlog=4'b0100 next cycle.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared types and constants for the writeback arbiter slice.
//   wb_src_e   : index of each writeback requester
//   DEF_*      : default sizing for the arbiter and its interface
//   wb_word_t  : packed registered writeback word {wr_en, rd_addr, data}
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

    localparam int XLEN        = 32;
    localparam int DEF_NUM_SRC = 4;
    localparam int DEF_TAG_W   = 4;   // width of the instr_tag field

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MUL = 2'd1,
        WB_SRC_DIV = 2'd2,
        WB_SRC_LSU = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic            wr_en;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] data;
    } wb_word_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// Requester-side bus of the writeback arbiter.
//   src_valid   : per-source result pending
//   src_rd_addr : per-source destination register
//   src_data    : per-source result
//   src_tag     : per-source issue-order tag
//   src_ready   : one-hot grant back to the sources
// Modports: master = execution units, slave = arbiter.
// -----------------------------------------------------------------------------
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int TAG_W   = DEF_TAG_W
);

    logic [NUM_SRC-1:0]             src_valid;
    logic [NUM_SRC-1:0][4:0]        src_rd_addr;
    logic [NUM_SRC-1:0][XLEN-1:0]   src_data;
    logic [NUM_SRC-1:0][TAG_W-1:0]  src_tag;
    logic [NUM_SRC-1:0]             src_ready;

    modport master (
        output src_valid, src_rd_addr, src_data, src_tag,
        input  src_ready
    );

    modport slave (
        input  src_valid, src_rd_addr, src_data, src_tag,
        output src_ready
    );

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// wb_arbiter_rr_pick
// Round-robin one-hot picker. Searches req starting at (last+1) mod N and
// grants the first set bit.
//   req     : eligible requests
//   last    : index of the previous grant
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : binary index of the grant (last when no request)
//   any     : a grant was issued
// -----------------------------------------------------------------------------
module wb_arbiter_rr_pick #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = last;
        any     = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Picks at most one execution-unit result per cycle for register writeback.
// Round-robin among sources, except that a source is held back while another
// pending source targets the same nonzero rd with an older tag (keeps WAW
// ordering in the register file).
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : src_valid/rd_addr/data/tag in, one-hot src_ready out
//   exu_wb_rd_addr  : registered writeback address
//   exu_wb_data     : registered writeback data
//   exu_wb_rd_wr_en : registered writeback strobe (0 for rd x0)
//   wb_backlog      : registered src_valid & ~src_ready
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_arbiter_if.slave        bus,
    output logic [4:0]         exu_wb_rd_addr,
    output logic [XLEN-1:0]    exu_wb_data,
    output logic               exu_wb_rd_wr_en,
    output logic [NUM_SRC-1:0] wb_backlog
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Modular age compare: a is older than b when (a - b) wraps negative.
    function automatic logic is_older(input logic [TAG_W-1:0] a,
                                      input logic [TAG_W-1:0] b);
        logic [TAG_W-1:0] diff;
        diff = a - b;
        return diff[TAG_W-1];
    endfunction

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   last_grant;
    logic               gnt_any;
    wb_word_t           wb_nxt;
    wb_word_t           wb_p1;

    // x0 writes never conflict, so they skip the WAW mask entirely.
    always_comb begin
        eligible = bus.src_valid;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                if (i != j && bus.src_valid[i] && bus.src_valid[j] &&
                    bus.src_rd_addr[i] != 5'd0 &&
                    bus.src_rd_addr[j] == bus.src_rd_addr[i] &&
                    is_older(bus.src_tag[j], bus.src_tag[i])) begin
                    eligible[i] = 1'b0;
                end
            end
        end
    end

    wb_arbiter_rr_pick #(.N(NUM_SRC)) u_pick (
        .req     (eligible),
        .last    (last_grant),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // Nothing is consumed while in reset; the requester re-presents it.
    assign bus.src_ready = rst_n ? gnt : '0;

    // Idle cycles keep address/data and only drop the strobe.
    always_comb begin
        wb_nxt       = wb_p1;
        wb_nxt.wr_en = 1'b0;
        if (gnt_any) begin
            wb_nxt.wr_en   = (bus.src_rd_addr[gnt_idx] != 5'd0);
            wb_nxt.rd_addr = bus.src_rd_addr[gnt_idx];
            wb_nxt.data    = bus.src_data[gnt_idx];
        end
    end

    // ---- stage p0 -> p1: grant registered onto the writeback port ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_p1      <= '0;
            wb_backlog <= '0;
            last_grant <= IDX_W'(NUM_SRC - 1);
        end else begin
            wb_p1      <= wb_nxt;
            wb_backlog <= bus.src_valid & ~bus.src_ready;
            if (gnt_any) begin
                last_grant <= gnt_idx;
            end
        end
    end

    assign exu_wb_rd_wr_en = wb_p1.wr_en;
    assign exu_wb_rd_addr  = wb_p1.rd_addr;
    assign exu_wb_data     = wb_p1.data;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NS = 4;
    localparam int TW = 4;

    logic            clk;
    logic            rst_n;
    logic [4:0]      exu_wb_rd_addr;
    logic [XLEN-1:0] exu_wb_data;
    logic            exu_wb_rd_wr_en;
    logic [NS-1:0]   wb_backlog;

    wb_arbiter_if #(.NUM_SRC(NS), .TAG_W(TW)) bus ();

    wb_arbiter #(.NUM_SRC(NS), .TAG_W(TW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .exu_wb_rd_addr  (exu_wb_rd_addr),
        .exu_wb_data     (exu_wb_data),
        .exu_wb_rd_wr_en (exu_wb_rd_wr_en),
        .wb_backlog      (wb_backlog)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // requester state (pending requests held until granted)
    logic [NS-1:0]           v;
    logic [NS-1:0][4:0]      rd;
    logic [NS-1:0][XLEN-1:0] dat;
    logic [NS-1:0][TW-1:0]   tg;

    // model state
    int              m_last;
    logic            exp_wr;
    logic [4:0]      exp_addr;
    logic [XLEN-1:0] exp_data;
    logic [NS-1:0]   exp_bl;

    // last observed DUT values
    logic [NS-1:0]   obs_ready;
    logic            obs_wr;
    logic [4:0]      obs_addr;
    logic [XLEN-1:0] obs_data;
    logic [NS-1:0]   obs_bl;

    logic [TW-1:0]   next_tag;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A source waits while a pending competitor writes the same nonzero rd
    // and was issued earlier (tag difference wraps into the upper half).
    function automatic bit blocked(input int s);
        int d;
        if (rd[s] == 5'd0) return 1'b0;
        for (int j = 0; j < NS; j++) begin
            if (j != s && v[j] && rd[j] == rd[s]) begin
                d = (int'(tg[j]) - int'(tg[s])) & ((1 << TW) - 1);
                if (d >= (1 << (TW - 1))) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int model_pick();
        int s;
        for (int k = 1; k <= NS; k++) begin
            s = (m_last + k) % NS;
            if (v[s] && !blocked(s)) return s;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last   = NS - 1;
        exp_wr   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_bl   = '0;
    endtask

    // One arbitration cycle: check registered outputs from the previous
    // cycle, present requests, check the grant, then advance the model.
    task automatic do_cycle();
        int g;
        logic [NS-1:0] gmask;
        @(negedge clk);
        obs_wr   = exu_wb_rd_wr_en;
        obs_addr = exu_wb_rd_addr;
        obs_data = exu_wb_data;
        obs_bl   = wb_backlog;
        check("wr_en", 64'(obs_wr), 64'(exp_wr));
        check("rd_addr", 64'(obs_addr), 64'(exp_addr));
        check("data", 64'(obs_data), 64'(exp_data));
        check("backlog", 64'(obs_bl), 64'(exp_bl));
        bus.src_valid   = v;
        bus.src_rd_addr = rd;
        bus.src_data    = dat;
        bus.src_tag     = tg;
        #1;
        g = model_pick();
        gmask = (g < 0) ? '0 : NS'(1 << g);
        obs_ready = bus.src_ready;
        check("src_ready", 64'(obs_ready), 64'(gmask));
        exp_bl = v & ~gmask;
        exp_wr = 1'b0;
        if (g >= 0) begin
            exp_wr   = (rd[g] != 5'd0);
            exp_addr = rd[g];
            exp_data = dat[g];
            m_last   = g;
            v[g]     = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 64'(bus.src_ready), 64'(0));
        check({tag, "_wr_en"}, 64'(exu_wb_rd_wr_en), 64'(0));
        check({tag, "_rd_addr"}, 64'(exu_wb_rd_addr), 64'(0));
        check({tag, "_data"}, 64'(exu_wb_data), 64'(0));
        check({tag, "_backlog"}, 64'(wb_backlog), 64'(0));
    endtask

    initial begin
        v = '0; rd = '0; dat = '0; tg = '0; next_tag = '0;
        bus.src_valid   = 4'b1111;
        bus.src_rd_addr = '0;
        bus.src_data    = '0;
        bus.src_tag     = '0;
        rst_n = 1'b0;
        model_reset();

        // power-on reset with requests pending
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        rst_n = 1'b1;

        // single source, same-cycle grant
        v[2] = 1'b1; rd[2] = 5'd5; dat[2] = 32'hDEAD_BEEF; tg[2] = 4'd0;
        do_cycle();
        check("single_ready", 64'(obs_ready), 64'(4'b0100));

        // x0 request alone; also observe the single-source writeback
        v[0] = 1'b1; rd[0] = 5'd0; dat[0] = 32'h1234_5678; tg[0] = 4'd1;
        do_cycle();
        check("single_wr_en", 64'(obs_wr), 64'(1));
        check("single_rd", 64'(obs_addr), 64'(5));
        check("single_data", 64'(obs_data), 64'(32'hDEAD_BEEF));
        check("x0_ready", 64'(obs_ready), 64'(4'b0001));

        // two requesters at once after the x0 grant
        v[1] = 1'b1; rd[1] = 5'd3; dat[1] = 32'h0000_0011; tg[1] = 4'd2;
        v[2] = 1'b1; rd[2] = 5'd4; dat[2] = 32'h0000_0022; tg[2] = 4'd3;
        do_cycle();
        check("x0_wr_en", 64'(obs_wr), 64'(0));
        check("bl_ready", 64'(obs_ready), 64'(4'b0010));
        do_cycle();
        check("backlog_bits", 64'(obs_bl), 64'(4'b0100));
        check("bl_ready2", 64'(obs_ready), 64'(4'b0100));

        // park last_grant on src0, then WAW on rd7
        v[0] = 1'b1; rd[0] = 5'd1; dat[0] = 32'h0000_0033; tg[0] = 4'd4;
        do_cycle();
        v[1] = 1'b1; rd[1] = 5'd7; dat[1] = 32'hAAAA_0001; tg[1] = 4'd3;
        v[3] = 1'b1; rd[3] = 5'd7; dat[3] = 32'hBBBB_0003; tg[3] = 4'd1;
        do_cycle();
        check("waw_first", 64'(obs_ready), 64'(4'b1000));
        do_cycle();
        check("waw_second", 64'(obs_ready), 64'(4'b0010));
        do_cycle();
        check("waw_final_rd", 64'(obs_addr), 64'(7));
        check("waw_final_data", 64'(obs_data), 64'(32'hAAAA_0001));

        // tag wrap: 15 is older than 0
        v[0] = 1'b1; rd[0] = 5'd9; dat[0] = 32'h0F0F_0000; tg[0] = 4'd15;
        v[1] = 1'b1; rd[1] = 5'd9; dat[1] = 32'h0F0F_0001; tg[1] = 4'd0;
        do_cycle();
        check("wrap_first", 64'(obs_ready), 64'(4'b0001));
        do_cycle();
        check("wrap_second", 64'(obs_ready), 64'(4'b0010));

        // park last_grant on src3, then four held requests
        v[3] = 1'b1; rd[3] = 5'd2; dat[3] = 32'h0000_0044; tg[3] = 4'd5;
        do_cycle();
        for (int i = 0; i < NS; i++) begin
            v[i] = 1'b1; rd[i] = 5'(i + 1); dat[i] = 32'hC0DE_0000 + i; tg[i] = 4'(6 + i);
        end
        for (int i = 0; i < NS; i++) begin
            do_cycle();
            check("rr_grant", 64'(obs_ready), 64'(1 << i));
            if (i > 0) check("rr_wr_en", 64'(obs_wr), 64'(1));
        end
        do_cycle();
        check("rr_wr_en_last", 64'(obs_wr), 64'(1));

        // reset mid-transaction with all four requesting
        for (int i = 0; i < NS; i++) begin
            v[i] = 1'b1; rd[i] = 5'(i + 10); dat[i] = 32'h5EED_0000 + i; tg[i] = 4'(10 + i);
        end
        do_cycle();
        check("mid_grant", 64'(obs_ready), 64'(4'b0001));
        @(negedge clk);
        v = 4'b1111;
        bus.src_valid = v;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        check_reset_state("midrst_hold");
        rst_n = 1'b1;
        model_reset();
        do_cycle();
        check("post_reset_grant", 64'(obs_ready), 64'(4'b0001));

        // random traffic; tags follow issue order
        v = '0;
        next_tag = 4'd0;
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < NS; s++) begin
                if (!v[s] && $urandom_range(0, 99) < 50) begin
                    v[s]   = 1'b1;
                    rd[s]  = 5'($urandom_range(0, 6));
                    dat[s] = $urandom;
                    tg[s]  = next_tag;
                    next_tag = next_tag + 4'd1;
                end
            end
            do_cycle();
        end
        v = '0;
        do_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
